// File: rtl/neurram_reg_control_multi.sv
// Register-chain controller for N_CH neuron/input register chains.
// Sequences SPI bulk shift, timed random-access writes and neuron read-out,
// and reports busy/done/error to the host sequencer.
module neurram_reg_control_multi #(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned SETUP_W = 1,
    parameter int unsigned PULSE_W = 1,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_spi_trigger,
    input  logic            i_rand_access_trigger,
    input  logic [N_CH-1:0] i_rand_access_ch_mask,
    input  logic            i_rand_access_vert,
    input  logic [N_CH-1:0] i_neuron_read_trigger,
    input  logic            i_shift_fwd,
    input  logic            i_inf_fwd,
    input  logic            i_state_spi_clk,
    input  logic            i_state_spi_idle,
    output logic [N_CH-1:0] o_spi_clk,
    output logic [1:0]      o_reg_config,
    output logic            o_reg_write_enable_horz,
    output logic            o_reg_write_enable_vert,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_error
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Counter load values: each phase counts down to zero inclusive
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_W - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_W - 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSpiTrig = 3'd1,
        StSpi     = 3'd2,
        StRaSetup = 3'd3,
        StRaPulse = 3'd4,
        StNread   = 3'd5
    } state_e;

    state_e            r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [N_CH-1:0]   r_mask, w_mask_next;
    logic              r_vert, w_vert_next;
    logic [CH_W-1:0]   r_ch, w_ch_next;
    logic              r_done, w_done_next;
    logic              r_error, w_error_next;
    logic [CH_W-1:0]   w_low_ch;
    logic [N_CH-1:0]   w_ch_onehot;

    // Lowest-index neuron read request wins
    always_comb begin
        w_low_ch = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (i_neuron_read_trigger[i]) begin
                w_low_ch = CH_W'(i);
            end
        end
    end

    assign w_ch_onehot = N_CH'(1) << r_ch;

    // State register plus counter, latched operands and status pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_vert  <= 1'b0;
            r_ch    <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_mask  <= w_mask_next;
            r_vert  <= w_vert_next;
            r_ch    <= w_ch_next;
            r_done  <= w_done_next;
            r_error <= w_error_next;
        end
    end

    // Next-state, counter and latch logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_mask_next  = r_mask;
        w_vert_next  = r_vert;
        w_ch_next    = r_ch;
        w_done_next  = 1'b0;
        w_error_next = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_spi_trigger) begin
                    w_state_next = StSpiTrig;
                    w_cnt_next   = TIMEOUT_LOAD;
                end else if (i_rand_access_trigger) begin
                    w_state_next = StRaSetup;
                    w_mask_next  = i_rand_access_ch_mask;
                    w_vert_next  = i_rand_access_vert;
                    w_cnt_next   = SETUP_LOAD;
                end else if (|i_neuron_read_trigger) begin
                    w_state_next = StNread;
                    w_ch_next    = w_low_ch;
                end
            end
            StSpiTrig: begin
                if (!i_state_spi_idle) begin
                    w_state_next = StSpi;
                end else if (r_cnt == '0) begin
                    w_state_next = StIdle;
                    w_error_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            StSpi: begin
                if (i_state_spi_idle) begin
                    w_state_next = StIdle;
                    w_done_next  = 1'b1;
                end
            end
            StRaSetup: begin
                if (r_cnt == '0) begin
                    w_state_next = StRaPulse;
                    w_cnt_next   = PULSE_LOAD;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            StRaPulse: begin
                if (r_cnt == '0) begin
                    w_state_next = StIdle;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            StNread: begin
                // Only the latched chain matters; other request bits are ignored
                if (!i_neuron_read_trigger[r_ch]) begin
                    w_state_next = StIdle;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        o_spi_clk               = '0;
        o_reg_config            = 2'b00;
        o_reg_write_enable_horz = 1'b0;
        o_reg_write_enable_vert = 1'b0;
        o_busy                  = 1'b0;
        case (r_state)
            StSpiTrig: begin
                o_reg_config            = {i_shift_fwd, 1'b1};
                o_reg_write_enable_horz = 1'b1;
                o_reg_write_enable_vert = 1'b1;
                o_busy                  = 1'b1;
            end
            StSpi: begin
                o_spi_clk               = {N_CH{i_state_spi_clk}};
                o_reg_config            = {i_shift_fwd, 1'b1};
                o_reg_write_enable_horz = 1'b1;
                o_reg_write_enable_vert = 1'b1;
                o_busy                  = 1'b1;
            end
            StRaSetup: begin
                o_reg_config            = 2'b10;
                o_reg_write_enable_horz = ~r_vert;
                o_reg_write_enable_vert = r_vert;
                o_busy                  = 1'b1;
            end
            StRaPulse: begin
                o_spi_clk               = r_mask;
                o_reg_config            = 2'b10;
                o_reg_write_enable_horz = ~r_vert;
                o_reg_write_enable_vert = r_vert;
                o_busy                  = 1'b1;
            end
            StNread: begin
                o_spi_clk               = w_ch_onehot;
                o_reg_write_enable_horz = i_inf_fwd;
                o_reg_write_enable_vert = ~i_inf_fwd;
                o_busy                  = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_done  = r_done;
    assign o_error = r_error;

endmodule
